countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
Sequencing controller for a loadable down counter. Accepts a start command with a load value and runs the count only on qualified ticks. Supports pause, resume and abort, and flags terminal count with a one-cycle done pulse. Sits between the system control logic and any timing or delay consumer that needs a programmable countdown with run-state status.

Parameters:
WIDTH, 4, counter width in bits; load_val and cnt are WIDTH bits wide.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  in IDLE: load and run; in PAUSE: resume; ignored in RUN and DONE
load_val  in  WIDTH  count value captured on an accepted start from IDLE
tick  in  1  count-enable qualifier; cnt decrements only on cycles where tick=1 in RUN
pause  in  1  in RUN: freeze the count (enter PAUSE)
abort  in  1  any state: return to IDLE and clear cnt
cnt  out  WIDTH  current count value
busy  out  1  1 while the state is RUN or PAUSE
done  out  1  registered pulse, 1 for exactly one cycle at terminal count
state  out  2  encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (sampled at posedge): state=IDLE, cnt=0, busy=0, done=0, captured reload value=0. Reset overrides every other input, including mid-count.
- Input priority per cycle: reset > abort > pause > start > tick.
- IDLE:
  - start=1 and load_val!=0: cnt<=load_val, capture load_val, go to RUN. busy=1 from the next cycle.
  - start=1 and load_val==0: go to DONE with done=1 next cycle; cnt stays 0.
- RUN:
  - pause=1: go to PAUSE, no decrement, even if tick=1.
  - tick=1 and cnt>1: cnt<=cnt-1.
  - tick=1 and cnt==1: cnt<=0, done<=1, go to DONE.
  - tick=0: hold.
  - start is ignored.
- PAUSE:
  - cnt holds; tick is ignored.
  - start=1: go to RUN. The first decrement can occur on the following edge.
  - pause is ignored while already paused.
- DONE: lasts one cycle; done=1, busy=0. Unconditionally return to IDLE next edge with done<=0. start is ignored in DONE.
- abort=1 in any state: state=IDLE, cnt=0, busy=0, done=0 next edge. abort in DONE suppresses nothing already emitted, but the next cycle is IDLE.
- Latency:
  - Accepted start at edge N: cnt=load_val after N.
  - Earliest decrement at edge N+1.
  - With tick held at 1, done goes high after edge N+load_val.
- Arithmetic: cnt never wraps below 0 (no decrement at 0). load_val is taken unsigned; max is 2^WIDTH-1.
- busy and done are never both 1.

Optional Feature:
COUNTDOWN_CTRL_AUTO_RELOAD_EN
- Defined: at terminal count in RUN (cnt==1, tick=1), cnt<=captured reload value, done<=1 for one cycle, and the state stays RUN (DONE is not entered). busy stays 1, and the count repeats until abort, pause or reset. start with load_val==0 still enters DONE once.
- Undefined: behaviour exactly as above (single-shot, RUN->DONE->IDLE).

Test Plan:
- Reset, then start with load_val=5 and tick=1 continuously -> cnt 5,4,3,2,1,0 on successive cycles. done=1 in the cycle cnt=0 with state=3, then state=0 and done=0 next cycle. busy=1 exactly over the 5 RUN cycles.
- load_val=6, tick=1 on alternate cycles only -> cnt decrements only on tick cycles. done occurs 12 cycles after start.
- load_val=9, pause asserted at cnt=6 for 4 cycles with tick=1 -> cnt holds 6 and state=2. Pulsing start resumes: cnt=5 one tick later. Also assert pause and tick in the same cycle -> no decrement.
- load_val=8, abort at cnt=3 -> next cycle state=0, cnt=0, busy=0, no done. Repeat with reset instead of abort -> same result. Assert start while in RUN -> cnt unaffected.
- start with load_val=0 -> DONE with done=1 for one cycle, busy never 1. Then load_val=15 (max) -> 15 decrements to 0, with no wrap to 15 after 0.
- With COUNTDOWN_CTRL_AUTO_RELOAD_EN, load_val=3, tick=1 -> cnt 3,2,1,3,2,1,... with done pulsed each time 1->reload. State stays 1 until abort.

Source files
------------

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - loadable down-counter sequencer with pause/resume/abort and done pulse
// Optional: `define COUNTDOWN_CTRL_AUTO_RELOAD_EN to reload and keep running at terminal count.
module countdown_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (load_val != '0) begin
              state_d = S_RUN;
              cnt_d   = load_val;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
              reload_d = load_val;
`endif
            end else begin
              state_d = S_DONE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          // pause wins over a same-cycle tick, so a paused count never slips
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            if (cnt_q > WIDTH'(1)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (cnt_q == WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
              cnt_d = reload_q;
`else
              cnt_d   = '0;
              state_d = S_DONE;
`endif
            end
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign cnt   = cnt_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - self-checking bench for countdown_ctrl (vector table plus scoreboard queue)
module tb_countdown_ctrl;
  localparam int W = 4;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, tick, pause, abort;
  logic [W-1:0] load_val, cnt;
  logic         busy, done;
  logic [1:0]   state;

  always #5 clk = ~clk;

  countdown_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val), .tick(tick),
    .pause(pause), .abort(abort), .cnt(cnt), .busy(busy), .done(done), .state(state)
  );

  typedef struct {
    logic [W-1:0] cnt;
    logic [1:0]   st;
    logic         busy;
    logic         done;
    string        tag;
  } exp_t;

  typedef struct {
    logic         rs, ab, pz, st;
    logic [W-1:0] lv;
    logic         tk;
    logic [W-1:0] ec;
    logic [1:0]   es;
    logic         eb, ed;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d", tag, field, act, exp);
    end
  endtask

  task automatic step(input logic rs, ab, pz, st, input logic [W-1:0] lv, input logic tk,
                      input logic [W-1:0] ec, input logic [1:0] es, input logic eb, ed,
                      input string tag);
    exp_t e;
    reset = rs; abort = ab; pause = pz; start = st; load_val = lv; tick = tk;
    e.cnt = ec; e.st = es; e.busy = eb; e.done = ed; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.scoreboard got=empty want=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(e.tag, "cnt",   32'(cnt),   32'(e.cnt));
      chk(e.tag, "state", 32'(state), 32'(e.st));
      chk(e.tag, "busy",  32'(busy),  32'(e.busy));
      chk(e.tag, "done",  32'(done),  32'(e.done));
    end
  endtask

  // terminal-count edge: single-shot enters DONE, auto-reload stays in RUN with the reload value
  task automatic step_term(input logic [W-1:0] rl, input string tag);
    step(0, 0, 0, 0, '0, 1, AUTO ? rl : '0, AUTO ? 2'd1 : 2'd3, AUTO, 1'b1, tag);
  endtask

  task automatic idle_abort(input string tag);
    step(0, 1, 0, 0, '0, 1, 0, 0, 0, 0, tag);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 4'd5, 1, 4'd5, 2'd1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 4'd0, 1, 4'd4, 2'd1, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 4'd0, 1, 4'd3, 2'd1, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 4'd0, 1, 4'd2, 2'd1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 4'd0, 1, 4'd1, 2'd1, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 4'd0, 1, AUTO ? 4'd5 : 4'd0, AUTO ? 2'd1 : 2'd3, AUTO, 1};
    tbl[7]  = '{0, 1, 0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 4'd0, 1, 4'd0, 2'd3, 0, 1};
    tbl[9]  = '{0, 0, 0, 1, 4'd5, 1, 4'd0, 2'd0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 4'd0, 1, 4'd0, 2'd0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 4'd0, 1, 4'd0, 2'd0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rs, tbl[i].ab, tbl[i].pz, tbl[i].st, tbl[i].lv, tbl[i].tk,
           tbl[i].ec, tbl[i].es, tbl[i].eb, tbl[i].ed, $sformatf("vec%0d", i));
    end

    // tick on alternate cycles: six decrements spread over twelve edges
    step(0, 0, 0, 1, 4'd6, 0, 4'd6, 1, 1, 0, "alt_load");
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) step_term(4'd6, "alt_done");
      else step(0, 0, 0, 0, '0, logic'(i % 2 == 0), W'(6 - i / 2), 1, 1, 0, $sformatf("alt%0d", i));
    end
    idle_abort("alt_clear");

    // pause / resume
    step(0, 0, 0, 1, 4'd9, 1, 4'd9, 1, 1, 0, "pz_load");
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, '0, 1, W'(9 - i), 1, 1, 0, $sformatf("pz_dec%0d", i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, '0, 1, 4'd6, 2, 1, 0, $sformatf("pz_hold%0d", i));
    step(0, 0, 0, 1, '0, 1, 4'd6, 1, 1, 0, "pz_resume");
    step(0, 0, 0, 0, '0, 1, 4'd5, 1, 1, 0, "pz_first_dec");
    step(0, 0, 1, 0, '0, 1, 4'd5, 2, 1, 0, "pz_and_tick");
    step(0, 0, 0, 1, '0, 0, 4'd5, 1, 1, 0, "pz_resume2");
    idle_abort("pz_abort");

    // abort mid-count, start ignored in RUN
    step(0, 0, 0, 1, 4'd8, 1, 4'd8, 1, 1, 0, "ab_load");
    step(0, 0, 0, 0, '0, 1, 4'd7, 1, 1, 0, "ab_dec7");
    step(0, 0, 0, 0, '0, 1, 4'd6, 1, 1, 0, "ab_dec6");
    step(0, 0, 0, 1, 4'd2, 1, 4'd5, 1, 1, 0, "start_in_run");
    step(0, 0, 0, 0, '0, 1, 4'd4, 1, 1, 0, "ab_dec4");
    step(0, 0, 0, 0, '0, 1, 4'd3, 1, 1, 0, "ab_dec3");
    step(0, 1, 0, 1, 4'd7, 1, 4'd0, 0, 0, 0, "ab_abort");
    step(0, 0, 0, 0, '0, 1, 4'd0, 0, 0, 0, "ab_no_done");

    // same with reset mid-count
    step(0, 0, 0, 1, 4'd8, 1, 4'd8, 1, 1, 0, "rs_load");
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, '0, 1, W'(8 - i), 1, 1, 0, $sformatf("rs_dec%0d", i));
    step(1, 0, 0, 1, 4'd4, 1, 4'd0, 0, 0, 0, "rs_reset");
    step(0, 0, 0, 0, '0, 1, 4'd0, 0, 0, 0, "rs_no_done");

    // max load, no wrap below zero
    step(0, 0, 0, 1, 4'd15, 1, 4'd15, 1, 1, 0, "max_load");
    for (int i = 1; i <= 14; i++) step(0, 0, 0, 0, '0, 1, W'(15 - i), 1, 1, 0, $sformatf("max_dec%0d", i));
    step_term(4'd15, "max_done");
    step(0, 0, 0, 0, '0, 1, AUTO ? 4'd14 : 4'd0, AUTO ? 2'd1 : 2'd0, AUTO, 0, "max_after");
    step(0, 0, 0, 0, '0, 1, AUTO ? 4'd13 : 4'd0, AUTO ? 2'd1 : 2'd0, AUTO, 0, "max_no_wrap");
    idle_abort("max_clear");

`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    step(0, 0, 0, 1, 4'd3, 1, 4'd3, 1, 1, 0, "ar_load");
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 0, 0, '0, 1, 4'd2, 1, 1, 0, $sformatf("ar%0d_2", r));
      step(0, 0, 0, 0, '0, 1, 4'd1, 1, 1, 0, $sformatf("ar%0d_1", r));
      step_term(4'd3, $sformatf("ar%0d_reload", r));
    end
    step(0, 0, 1, 0, '0, 1, 4'd3, 2, 1, 0, "ar_pause");
    step(0, 0, 0, 1, '0, 1, 4'd3, 1, 1, 0, "ar_resume");
    step(0, 0, 0, 0, '0, 1, 4'd2, 1, 1, 0, "ar_dec");
    idle_abort("ar_abort");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
